// File: rtl/traffic_sigctrl_if.sv
// Traffic signal controller bundle: the country-road sensor input and the
// two light outputs. The bench drives car_on and observes the lights.
interface traffic_sigctrl_if;
  logic       car_on;
  logic [1:0] main_sig;
  logic [1:0] cntry_sig;

  // Environment side: presents the sensor and watches the lights.
  modport master (
    output car_on,
    input  main_sig,
    input  cntry_sig
  );

  // Controller side: consumes the sensor and drives the lights.
  modport slave (
    input  car_on,
    output main_sig,
    output cntry_sig
  );
endinterface

// File: rtl/traffic_sigctrl.sv
// Highway / country-road traffic light controller.
// Five-state Moore FSM. The two yellow phases and the all-red phase are timed
// by a 4-bit down-counter that is loaded with (delay-1) on entry and releases
// the transition when it reads zero. Light outputs are registered copies of
// the decode of the next state, so they always reflect the state register
// and CAR_ON has no combinational path to them.
module traffic_sigctrl #(
  parameter int unsigned Y2R_DELAY = 3,
  parameter int unsigned R2G_DELAY = 2
) (
  output logic [1:0] MAIN_SIG,
  output logic [1:0] CNTRY_SIG,
  input  logic       CAR_ON,
  input  logic       CLK,
  input  logic       CLEAR
);

  localparam logic [1:0] LIGHT_RED    = 2'd0;
  localparam logic [1:0] LIGHT_YELLOW = 2'd1;
  localparam logic [1:0] LIGHT_GREEN  = 2'd2;

  localparam logic [3:0] Y_LOAD = 4'(Y2R_DELAY - 32'd1);
  localparam logic [3:0] R_LOAD = 4'(R2G_DELAY - 32'd1);

  typedef enum logic [2:0] {
    S0 = 3'd0,  // main green, country red
    S1 = 3'd1,  // main yellow, country red
    S2 = 3'd2,  // all red
    S3 = 3'd3,  // main red, country green
    S4 = 3'd4   // main red, country yellow
  } state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic [3:0] r_cnt;
  logic [3:0] w_next_cnt;
  logic [1:0] r_main;
  logic [1:0] r_cntry;

  // Main-road light for a given state; anything unknown shows the safe S0 pattern.
  function automatic logic [1:0] main_light(input state_t s);
    logic [1:0] v;
    case (s)
      S0:      v = LIGHT_GREEN;
      S1:      v = LIGHT_YELLOW;
      S2:      v = LIGHT_RED;
      S3:      v = LIGHT_RED;
      S4:      v = LIGHT_RED;
      default: v = LIGHT_GREEN;
    endcase
    return v;
  endfunction

  // Country-road light for a given state; never non-red together with main.
  function automatic logic [1:0] cntry_light(input state_t s);
    logic [1:0] v;
    case (s)
      S0:      v = LIGHT_RED;
      S1:      v = LIGHT_RED;
      S2:      v = LIGHT_RED;
      S3:      v = LIGHT_GREEN;
      S4:      v = LIGHT_YELLOW;
      default: v = LIGHT_RED;
    endcase
    return v;
  endfunction

  // Next-state and dwell-counter logic; timed states ignore CAR_ON entirely.
  always_comb begin
    w_next_state = S0;
    w_next_cnt   = 4'd0;
    case (r_state)
      S0: begin
        if (CAR_ON) begin
          w_next_state = S1;
          w_next_cnt   = Y_LOAD;
        end else begin
          w_next_state = S0;
          w_next_cnt   = 4'd0;
        end
      end
      S1: begin
        if (r_cnt == 4'd0) begin
          w_next_state = S2;
          w_next_cnt   = R_LOAD;
        end else begin
          w_next_state = S1;
          w_next_cnt   = r_cnt - 4'd1;
        end
      end
      S2: begin
        if (r_cnt == 4'd0) begin
          w_next_state = S3;
          w_next_cnt   = 4'd0;
        end else begin
          w_next_state = S2;
          w_next_cnt   = r_cnt - 4'd1;
        end
      end
      S3: begin
        if (CAR_ON) begin
          w_next_state = S3;
          w_next_cnt   = 4'd0;
        end else begin
          w_next_state = S4;
          w_next_cnt   = Y_LOAD;
        end
      end
      S4: begin
        if (r_cnt == 4'd0) begin
          w_next_state = S0;
          w_next_cnt   = 4'd0;
        end else begin
          w_next_state = S4;
          w_next_cnt   = r_cnt - 4'd1;
        end
      end
      default: begin
        w_next_state = S0;
        w_next_cnt   = 4'd0;
      end
    endcase
  end

  // State, counter and light registers; CLEAR low overrides every transition.
  always_ff @(posedge CLK) begin
    if (!CLEAR) begin
      r_state <= S0;
      r_cnt   <= 4'd0;
      r_main  <= LIGHT_GREEN;
      r_cntry <= LIGHT_RED;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      r_main  <= main_light(w_next_state);
      r_cntry <= cntry_light(w_next_state);
    end
  end

  assign MAIN_SIG  = r_main;
  assign CNTRY_SIG = r_cntry;

endmodule

// File: tb/tb_traffic_sigctrl.sv
// Self-checking bench for traffic_sigctrl: directed scenarios plus a random
// run, all compared against a phase/timer model of the light sequence.
module tb_traffic_sigctrl;

  localparam int Y = 3;
  localparam int R = 2;

  logic clk;
  logic clear;

  int n_pass;
  int n_total;
  bit chk_on;

  // Reference model: current phase (0..4 = S0..S4) and cycles left in it.
  int m_phase;
  int m_left;

  traffic_sigctrl_if bus ();

  traffic_sigctrl #(.Y2R_DELAY(Y), .R2G_DELAY(R)) dut (
    .MAIN_SIG  (bus.main_sig),
    .CNTRY_SIG (bus.cntry_sig),
    .CAR_ON    (bus.car_on),
    .CLK       (clk),
    .CLEAR     (clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] exp_main(input int p);
    case (p)
      0:       return 2'd2;
      1:       return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] exp_cntry(input int p);
    case (p)
      3:       return 2'd2;
      4:       return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  // Apply inputs, advance one rising edge, update the model, settle.
  task automatic step(input logic car, input logic clr);
    bus.car_on = car;
    clear      = clr;
    @(posedge clk);
    if (!clr) begin
      m_phase = 0;
      m_left  = 0;
    end else begin
      case (m_phase)
        0: if (car) begin m_phase = 1; m_left = Y; end
        1: begin m_left = m_left - 1; if (m_left == 0) begin m_phase = 2; m_left = R; end end
        2: begin m_left = m_left - 1; if (m_left == 0) begin m_phase = 3; m_left = 0; end end
        3: if (!car) begin m_phase = 4; m_left = Y; end
        4: begin m_left = m_left - 1; if (m_left == 0) begin m_phase = 0; m_left = 0; end end
        default: m_phase = 0;
      endcase
    end
    #1;
  endtask

  // Lights must never show code 3 nor two non-red lights at once.
  always @(negedge clk) begin
    if (chk_on) begin
      n_total++;
      if (bus.main_sig === 2'd3 || bus.cntry_sig === 2'd3 ||
          (bus.main_sig !== 2'd0 && bus.cntry_sig !== 2'd0) ||
          $isunknown({bus.main_sig, bus.cntry_sig})) begin
        $display("FAIL safety: main=%0d cntry=%0d required legal and not both non-red",
                 bus.main_sig, bus.cntry_sig);
      end else begin
        n_pass++;
      end
    end
  end

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0);
      chk_on = 1'b1;
      n_total++;
      if (bus.main_sig !== 2'd2 || bus.cntry_sig !== 2'd0) begin
        $display("FAIL reset_hold[%0d]: main=%0d cntry=%0d required 2/0", i, bus.main_sig, bus.cntry_sig);
      end else n_pass++;
    end
    step(1'b1, 1'b1);
    n_total++;
    if (bus.main_sig !== 2'd1 || bus.cntry_sig !== 2'd0) begin
      $display("FAIL reset_release: main=%0d cntry=%0d required 1/0", bus.main_sig, bus.cntry_sig);
    end else n_pass++;
  endtask

  task automatic test_sequence();
    int em[9] = '{1, 1, 1, 0, 0, 2 - 2, 0, 0, 0};
    int ec[9] = '{0, 0, 0, 0, 0, 2, 2, 2, 2};
    step(1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b1);
      n_total++;
      if (bus.main_sig !== 2'(em[i]) || bus.cntry_sig !== 2'(ec[i])) begin
        $display("FAIL seq[%0d]: main=%0d cntry=%0d required %0d/%0d",
                 i, bus.main_sig, bus.cntry_sig, em[i], ec[i]);
      end else n_pass++;
    end
  endtask

  task automatic test_drop();
    int em[4] = '{0, 0, 0, 2};
    int ec[4] = '{1, 1, 1, 0};
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1);
      n_total++;
      if (bus.main_sig !== 2'(em[i]) || bus.cntry_sig !== 2'(ec[i])) begin
        $display("FAIL drop[%0d]: main=%0d cntry=%0d required %0d/%0d",
                 i, bus.main_sig, bus.cntry_sig, em[i], ec[i]);
      end else n_pass++;
    end
  endtask

  task automatic test_pulse();
    int away;
    int s3_len;
    away   = 1;
    s3_len = 0;
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1);
      n_total++;
      if (bus.main_sig !== exp_main(m_phase) || bus.cntry_sig !== exp_cntry(m_phase)) begin
        $display("FAIL pulse_model[%0d]: main=%0d cntry=%0d required %0d/%0d",
                 i, bus.main_sig, bus.cntry_sig, exp_main(m_phase), exp_cntry(m_phase));
      end else n_pass++;
      if (bus.main_sig === 2'd2) break;
      away++;
      if (bus.cntry_sig === 2'd2) s3_len++;
    end
    n_total++;
    if (away !== 9) begin
      $display("FAIL pulse_total: cycles=%0d required 9", away);
    end else n_pass++;
    n_total++;
    if (s3_len !== 1) begin
      $display("FAIL pulse_s3: cycles=%0d required 1", s3_len);
    end else n_pass++;
  endtask

  task automatic test_reset_mid();
    // Reset during all-red.
    step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
    n_total++;
    if (bus.main_sig !== 2'd0 || bus.cntry_sig !== 2'd0) begin
      $display("FAIL mid_reach_s2: main=%0d cntry=%0d required 0/0", bus.main_sig, bus.cntry_sig);
    end else n_pass++;
    step(1'b1, 1'b0);
    n_total++;
    if (bus.main_sig !== 2'd2 || bus.cntry_sig !== 2'd0) begin
      $display("FAIL mid_reset_s2: main=%0d cntry=%0d required 2/0", bus.main_sig, bus.cntry_sig);
    end else n_pass++;
    // Reset during country yellow.
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    n_total++;
    if (bus.main_sig !== 2'd0 || bus.cntry_sig !== 2'd1) begin
      $display("FAIL mid_reach_s4: main=%0d cntry=%0d required 0/1", bus.main_sig, bus.cntry_sig);
    end else n_pass++;
    step(1'b0, 1'b0);
    n_total++;
    if (bus.main_sig !== 2'd2 || bus.cntry_sig !== 2'd0) begin
      $display("FAIL mid_reset_s4: main=%0d cntry=%0d required 2/0", bus.main_sig, bus.cntry_sig);
    end else n_pass++;
  endtask

  task automatic test_ignore();
    int len_y1, len_rr, len_y2, run, code, prev;
    len_y1 = 0; len_rr = 0; len_y2 = 0; run = 0; prev = -1;
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    for (int i = 0; i < 60; i++) begin
      code = (bus.main_sig == 2'd1) ? 1 :
             (bus.cntry_sig == 2'd1) ? 4 :
             (bus.main_sig == 2'd0 && bus.cntry_sig == 2'd0) ? 2 :
             (bus.cntry_sig == 2'd2) ? 3 : 0;
      if (code == prev) run++;
      else begin
        if (prev == 1 && len_y1 == 0) len_y1 = run;
        if (prev == 2 && len_rr == 0) len_rr = run;
        if (prev == 4 && len_y2 == 0) len_y2 = run;
        prev = code;
        run  = 1;
      end
      if (len_y2 != 0) break;
      step(1'($urandom_range(0, 1)), 1'b1);
      n_total++;
      if (bus.main_sig !== exp_main(m_phase) || bus.cntry_sig !== exp_cntry(m_phase)) begin
        $display("FAIL ignore_model[%0d]: main=%0d cntry=%0d required %0d/%0d",
                 i, bus.main_sig, bus.cntry_sig, exp_main(m_phase), exp_cntry(m_phase));
      end else n_pass++;
    end
    n_total++;
    if (len_y1 !== Y || len_rr !== R || len_y2 !== Y) begin
      $display("FAIL ignore_dwell: y1=%0d red=%0d y2=%0d required %0d/%0d/%0d",
               len_y1, len_rr, len_y2, Y, R, Y);
    end else n_pass++;
  endtask

  task automatic test_random();
    logic car, clr;
    step(1'b0, 1'b0);
    for (int i = 0; i < 400; i++) begin
      car = ($urandom_range(0, 3) != 0) ? 1'(i[4]) : 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 31) != 0);
      step(car, clr);
      n_total++;
      if (bus.main_sig !== exp_main(m_phase) || bus.cntry_sig !== exp_cntry(m_phase)) begin
        $display("FAIL random[%0d]: main=%0d cntry=%0d required %0d/%0d",
                 i, bus.main_sig, bus.cntry_sig, exp_main(m_phase), exp_cntry(m_phase));
      end else n_pass++;
    end
  endtask

  initial begin
    n_pass     = 0;
    n_total    = 0;
    chk_on     = 1'b0;
    m_phase    = 0;
    m_left     = 0;
    bus.car_on = 1'b0;
    clear      = 1'b0;
    test_reset();
    test_sequence();
    test_drop();
    test_pulse();
    test_reset_mid();
    test_ignore();
    test_random();
    @(negedge clk);
    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
